phy_dly_seq: RTL and testbench

PHY_DLY_SEQ -- requirements
Module: phy_dly_seq

---
 rtl/phy_dly_seq.sv | 168 ++++++++++++++++
 tb/tb_phy_dly_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/phy_dly_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | phy_dly_seq : per-byte-lane IDELAY/ODELAY load and apply sequencer          |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module phy_dly_seq #(
  parameter int NUM_DLY = 10
) (
  input  logic               clk_div,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic               cmd_dir,
  input  logic [4:0]         cmd_addr,
  input  logic [7:0]         cmd_data,
  output logic [7:0]         dly_data,
  output logic [NUM_DLY-1:0] set_idelay,
  output logic [NUM_DLY-1:0] set_odelay,
  output logic [NUM_DLY-1:0] ld_idelay,
  output logic [NUM_DLY-1:0] ld_odelay,
  output logic [NUM_DLY-1:0] pend_i,
  output logic [NUM_DLY-1:0] pend_o,
  output logic               err
);

  localparam logic [1:0] c_OP_SET       = 2'b00;
  localparam logic [1:0] c_OP_SET_APPLY = 2'b01;
  localparam logic [1:0] c_OP_APPLY     = 2'b10;
  localparam logic [1:0] c_OP_CLEAR     = 2'b11;
  localparam logic [4:0] c_ADDR_BCAST   = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SET  = 2'd1,
    GAP  = 2'd2,
    LD   = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_dir, w_dir_nxt;
  logic                 r_apply, w_apply_nxt;
  logic [7:0]           r_dly, w_dly_nxt;
  logic [NUM_DLY-1:0]   r_set_i, w_set_i_nxt;
  logic [NUM_DLY-1:0]   r_set_o, w_set_o_nxt;
  logic [NUM_DLY-1:0]   r_ld_i, w_ld_i_nxt;
  logic [NUM_DLY-1:0]   r_ld_o, w_ld_o_nxt;
  logic [NUM_DLY-1:0]   r_pend_i, w_pend_i_nxt;
  logic [NUM_DLY-1:0]   r_pend_o, w_pend_o_nxt;
  logic                 r_err, w_err_nxt;
  logic [NUM_DLY-1:0]   w_mask;
  logic                 w_addr_ok;

  // Target select decode; address 31 hits every lane target.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NUM_DLY; i++) begin
      w_mask[i] = (cmd_addr == c_ADDR_BCAST) || (cmd_addr == 5'(i));
    end
    w_addr_ok = (cmd_addr == c_ADDR_BCAST) || (int'(cmd_addr) < NUM_DLY);
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_dir_nxt    = r_dir;
    w_apply_nxt  = r_apply;
    w_dly_nxt    = r_dly;
    w_set_i_nxt  = '0;
    w_set_o_nxt  = '0;
    w_ld_i_nxt   = '0;
    w_ld_o_nxt   = '0;
    w_pend_i_nxt = r_pend_i;
    w_pend_o_nxt = r_pend_o;
    w_err_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            c_OP_SET, c_OP_SET_APPLY: begin
              if (w_addr_ok) begin
                w_state_nxt = SET;
                w_dir_nxt   = cmd_dir;
                w_apply_nxt = (cmd_op == c_OP_SET_APPLY);
                w_dly_nxt   = cmd_data;
                if (cmd_dir) w_set_o_nxt = w_mask;
                else         w_set_i_nxt = w_mask;
              end else begin
                w_err_nxt = 1'b1;
              end
            end
            c_OP_APPLY: begin
              w_state_nxt = LD;
              w_dir_nxt   = cmd_dir;
              if (cmd_dir) w_ld_o_nxt = r_pend_o;
              else         w_ld_i_nxt = r_pend_i;
            end
            c_OP_CLEAR: begin
              if (cmd_dir) w_pend_o_nxt = '0;
              else         w_pend_i_nxt = '0;
            end
            default: ;
          endcase
        end
      end
      SET: begin
        // Only the active direction's strobe is nonzero, so OR-ing both is safe.
        w_pend_i_nxt = r_pend_i | r_set_i;
        w_pend_o_nxt = r_pend_o | r_set_o;
        w_state_nxt  = GAP;
      end
      GAP: begin
        if (r_apply) begin
          w_state_nxt = LD;
          if (r_dir) w_ld_o_nxt = r_pend_o;
          else       w_ld_i_nxt = r_pend_i;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      LD: begin
        if (r_dir) w_pend_o_nxt = '0;
        else       w_pend_i_nxt = '0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_dir    <= 1'b0;
      r_apply  <= 1'b0;
      r_dly    <= '0;
      r_set_i  <= '0;
      r_set_o  <= '0;
      r_ld_i   <= '0;
      r_ld_o   <= '0;
      r_pend_i <= '0;
      r_pend_o <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_dir    <= w_dir_nxt;
      r_apply  <= w_apply_nxt;
      r_dly    <= w_dly_nxt;
      r_set_i  <= w_set_i_nxt;
      r_set_o  <= w_set_o_nxt;
      r_ld_i   <= w_ld_i_nxt;
      r_ld_o   <= w_ld_o_nxt;
      r_pend_i <= w_pend_i_nxt;
      r_pend_o <= w_pend_o_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign cmd_ready  = (r_state == IDLE);
  assign dly_data   = r_dly;
  assign set_idelay = r_set_i;
  assign set_odelay = r_set_o;
  assign ld_idelay  = r_ld_i;
  assign ld_odelay  = r_ld_o;
  assign pend_i     = r_pend_i;
  assign pend_o     = r_pend_o;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_phy_dly_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_phy_dly_seq : scoreboard bench for phy_dly_seq (NUM_DLY = 10)            |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_phy_dly_seq;

  localparam int N = 10;

  typedef struct packed {
    int          cyc;
    logic [9:0]  si;
    logic [9:0]  so;
    logic [9:0]  li;
    logic [9:0]  lo;
    logic        er;
    logic [7:0]  dly;
    logic [9:0]  pi;
    logic [9:0]  po;
  } ev_t;

  logic         clk_div = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic         cmd_dir;
  logic [4:0]   cmd_addr;
  logic [7:0]   cmd_data;
  logic [7:0]   dly_data;
  logic [N-1:0] set_idelay, set_odelay, ld_idelay, ld_odelay, pend_i, pend_o;
  logic         err;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   t;
  ev_t  q[$];

  phy_dly_seq #(.NUM_DLY(N)) dut (
    .clk_div    (clk_div),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_dir    (cmd_dir),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .dly_data   (dly_data),
    .set_idelay (set_idelay),
    .set_odelay (set_odelay),
    .ld_idelay  (ld_idelay),
    .ld_odelay  (ld_odelay),
    .pend_i     (pend_i),
    .pend_o     (pend_o),
    .err        (err)
  );

  always #5 clk_div = ~clk_div;
  always @(posedge clk_div) cyc <= cyc + 1;

  // Monitor: any strobe or err is a DUT output event matched against the queue.
  always @(negedge clk_div) begin
    if ((set_idelay | set_odelay | ld_idelay | ld_odelay) != '0 || err) begin
      ev_t got, want;
      got = '{cyc, set_idelay, set_odelay, ld_idelay, ld_odelay, err, dly_data, pend_i, pend_o};
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: got cyc=%0d si=%h so=%h li=%h lo=%h err=%b dly=%h pi=%h po=%h, want none",
                 got.cyc, got.si, got.so, got.li, got.lo, got.er, got.dly, got.pi, got.po);
      end else begin
        want = q.pop_front();
        if (got !== want) begin
          bad++;
          $display("FAIL event: got cyc=%0d si=%h so=%h li=%h lo=%h err=%b dly=%h pi=%h po=%h, want cyc=%0d si=%h so=%h li=%h lo=%h err=%b dly=%h pi=%h po=%h",
                   got.cyc, got.si, got.so, got.li, got.lo, got.er, got.dly, got.pi, got.po,
                   want.cyc, want.si, want.so, want.li, want.lo, want.er, want.dly, want.pi, want.po);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic exp_ev(input int c, input logic [9:0] si, input logic [9:0] so,
                        input logic [9:0] li, input logic [9:0] lo, input logic er,
                        input logic [7:0] d, input logic [9:0] pi, input logic [9:0] po);
    ev_t e;
    e = '{c, si, so, li, lo, er, d, pi, po};
    q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge just after the accept edge.
  task automatic send(input logic [1:0] op, input logic dir, input logic [4:0] addr,
                      input logic [7:0] data);
    chk("ready_at_issue", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_dir   = dir;
    cmd_addr  = addr;
    cmd_data  = data;
    @(negedge clk_div);
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_div);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_dir = 1'b0;
    cmd_addr = 5'd0; cmd_data = 8'd0;
    idle(3);
    chk("reset_outputs", {dly_data, pend_i, pend_o, err, 1'b0},
        {8'h00, 10'h000, 10'h000, 1'b0, 1'b0});
    rst_n = 1'b1;
    idle(1);
    chk("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

    // SET_APPLY dir=1 addr=3 data=5A, with a busy-time command that must be ignored
    t = cyc;
    exp_ev(t + 1, 10'h000, 10'h008, 10'h000, 10'h000, 1'b0, 8'h5A, 10'h000, 10'h000);
    exp_ev(t + 3, 10'h000, 10'h000, 10'h000, 10'h008, 1'b0, 8'h5A, 10'h000, 10'h008);
    send(2'b01, 1'b1, 5'd3, 8'h5A);
    chk("sa_busy1", {31'd0, cmd_ready}, 32'd0);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_dir = 1'b1; cmd_addr = 5'd5; cmd_data = 8'hEE;
    idle(1);
    chk("sa_busy2", {31'd0, cmd_ready}, 32'd0);
    idle(1);
    chk("sa_busy3", {31'd0, cmd_ready}, 32'd0);
    cmd_valid = 1'b0;
    idle(1);
    chk("sa_ready4", {31'd0, cmd_ready}, 32'd1);
    chk("sa_pend_o", {22'd0, pend_o}, 32'h0);

    // Two SETs to input delays, then APPLY
    t = cyc;
    exp_ev(t + 1, 10'h001, 10'h000, 10'h000, 10'h000, 1'b0, 8'h11, 10'h000, 10'h000);
    send(2'b00, 1'b0, 5'd0, 8'h11);
    idle(2);
    t = cyc;
    exp_ev(t + 1, 10'h080, 10'h000, 10'h000, 10'h000, 1'b0, 8'h22, 10'h001, 10'h000);
    send(2'b00, 1'b0, 5'd7, 8'h22);
    idle(2);
    chk("pend_i_before_apply", {22'd0, pend_i}, 32'h081);
    t = cyc;
    exp_ev(t + 1, 10'h000, 10'h000, 10'h081, 10'h000, 1'b0, 8'h22, 10'h081, 10'h000);
    send(2'b10, 1'b0, 5'd31, 8'h99);
    chk("apply_busy", {31'd0, cmd_ready}, 32'd0);
    idle(1);
    chk("pend_i_after_apply", {22'd0, pend_i}, 32'h0);
    chk("dly_after_apply", {24'd0, dly_data}, 32'h22);

    // Broadcast SET to output delays
    t = cyc;
    exp_ev(t + 1, 10'h000, 10'h3FF, 10'h000, 10'h000, 1'b0, 8'hFF, 10'h000, 10'h000);
    send(2'b00, 1'b1, 5'd31, 8'hFF);
    idle(1);
    chk("bcast_pend_o", {22'd0, pend_o}, 32'h3FF);
    idle(1);
    chk("bcast_pend_i", {22'd0, pend_i}, 32'h0);

    // CLEAR of input mask, APPLY with nothing pending, then drain output mask
    t = cyc;
    exp_ev(t + 1, 10'h004, 10'h000, 10'h000, 10'h000, 1'b0, 8'h33, 10'h000, 10'h3FF);
    send(2'b00, 1'b0, 5'd2, 8'h33);
    idle(2);
    chk("pend_i_004", {12'd0, pend_i, pend_o}, {12'd0, 10'h004, 10'h3FF});
    send(2'b11, 1'b0, 5'd0, 8'h00);
    chk("clear_pend", {11'd0, cmd_ready, pend_i, pend_o}, {11'd0, 1'b1, 10'h000, 10'h3FF});
    send(2'b10, 1'b0, 5'd0, 8'h00);
    chk("empty_apply_busy", {31'd0, cmd_ready}, 32'd0);
    idle(1);
    t = cyc;
    exp_ev(t + 1, 10'h000, 10'h000, 10'h000, 10'h3FF, 1'b0, 8'h33, 10'h000, 10'h3FF);
    send(2'b10, 1'b1, 5'd0, 8'h00);
    idle(1);
    chk("pend_o_drained", {22'd0, pend_o}, 32'h0);

    // Invalid addresses and the last valid one
    t = cyc;
    exp_ev(t + 1, 10'h000, 10'h000, 10'h000, 10'h000, 1'b1, 8'h33, 10'h000, 10'h000);
    send(2'b00, 1'b0, 5'd12, 8'h77);
    chk("err12_ready_dly", {23'd0, cmd_ready, dly_data}, {23'd0, 1'b1, 8'h33});
    t = cyc;
    exp_ev(t + 1, 10'h000, 10'h000, 10'h000, 10'h000, 1'b1, 8'h33, 10'h000, 10'h000);
    send(2'b01, 1'b1, 5'd30, 8'h88);
    chk("err30_ready", {31'd0, cmd_ready}, 32'd1);
    t = cyc;
    exp_ev(t + 1, 10'h200, 10'h000, 10'h000, 10'h000, 1'b0, 8'h44, 10'h000, 10'h000);
    send(2'b00, 1'b0, 5'd9, 8'h44);
    idle(2);
    chk("addr9_pend_i", {22'd0, pend_i}, 32'h200);
    send(2'b11, 1'b0, 5'd0, 8'h00);

    // Reset during GAP of a SET_APPLY
    t = cyc;
    exp_ev(t + 1, 10'h002, 10'h000, 10'h000, 10'h000, 1'b0, 8'h66, 10'h000, 10'h000);
    send(2'b01, 1'b0, 5'd1, 8'h66);
    idle(1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_state",
        {set_idelay, set_odelay, ld_idelay, ld_odelay, pend_i, pend_o, dly_data, err},
        {10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 8'h00, 1'b0});
    idle(2);
    rst_n = 1'b1;
    chk("ready_after_release", {31'd0, cmd_ready}, 32'd1);
    idle(3);
    chk("pend_after_release", {12'd0, pend_i, pend_o}, 32'h0);

    t = cyc;
    exp_ev(t + 1, 10'h000, 10'h010, 10'h000, 10'h000, 1'b0, 8'h5C, 10'h000, 10'h000);
    exp_ev(t + 3, 10'h000, 10'h000, 10'h000, 10'h010, 1'b0, 8'h5C, 10'h000, 10'h010);
    send(2'b01, 1'b1, 5'd4, 8'h5C);
    idle(3);
    chk("post_reset_sa", {23'd0, cmd_ready, 8'h00} | {22'd0, pend_o}, {23'd0, 1'b1, 8'h00});

    idle(2);
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
